// File: rtl/grb_frame_sequencer.sv
// Frame sequencer for the GRB pixel shipper: walks pixel memory, hands each
// 24-bit word to the shipper over a go/done handshake, then holds the latch gap.
module grb_frame_sequencer #(
    parameter int ADDR_W       = 8,
    parameter int MAX_LEDS     = 256,
    parameter int LATCH_CYCLES = 5000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              loop_en,
    input  logic [ADDR_W:0]   led_count,
    output logic              pix_rd,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [23:0]       pix_data,
    output logic [23:0]       ship_data,
    output logic              ship_go,
    input  logic              ship_done,
    output logic              busy,
    output logic              frame_done
);

    localparam int              LAT_W    = $clog2(LATCH_CYCLES + 1);
    localparam logic [ADDR_W:0] MAX_CNT  = (ADDR_W + 1)'(MAX_LEDS);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);

    // FETCH and SHIP each own a state bit so pix_rd and ship_go come straight off a flop
    typedef enum logic [3:0] {
        IDLE  = 4'b0000,
        FETCH = 4'b0001,
        SHIP  = 4'b0010,
        LOAD  = 4'b0100,
        NEXT  = 4'b1000,
        LATCH = 4'b1100
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W:0]    frame_len;
    logic [ADDR_W:0]    clamped;
    logic [LAT_W-1:0]   latch_cnt;
    logic               begin_frame;
    logic               last_pix;
    logic               latch_end;

    assign clamped   = (led_count > MAX_CNT) ? MAX_CNT : led_count;
    assign last_pix  = ({1'b0, pix_addr} == (frame_len - (ADDR_W + 1)'(1)));
    assign latch_end = (latch_cnt == LAT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        begin_frame = 1'b0;
        pix_rd      = state[0];
        ship_go     = state[1];
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (start && (clamped != '0)) begin
                    begin_frame = 1'b1;
                    state_nxt   = FETCH;
                end
            end
            FETCH: state_nxt = LOAD;
            LOAD:  state_nxt = SHIP;
            SHIP: begin
                if (ship_done) begin
                    state_nxt = NEXT;
                end
            end
            NEXT:  state_nxt = last_pix ? LATCH : FETCH;
            LATCH: begin
                // loop_en and led_count are only looked at when the gap ends
                if (latch_end) begin
                    if (loop_en && (clamped != '0)) begin
                        begin_frame = 1'b1;
                        state_nxt   = FETCH;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_addr   <= '0;
            ship_data  <= '0;
            latch_cnt  <= '0;
            frame_len  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == LATCH) && latch_end;
            if (begin_frame) begin
                frame_len <= clamped;
                pix_addr  <= '0;
            end else if ((state == NEXT) && !last_pix) begin
                pix_addr <= pix_addr + ADDR_W'(1);
            end
            if (state == LOAD) begin
                ship_data <= pix_data;
            end
            if ((state == NEXT) && last_pix) begin
                latch_cnt <= '0;
            end else if (state == LATCH) begin
                latch_cnt <= latch_cnt + LAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_grb_frame_sequencer.sv
// Directed bench for grb_frame_sequencer: table of single-shot frames plus
// hand-written sequences for looping, spurious done, reset and ignored inputs.
module tb_grb_frame_sequencer;

    localparam int ADDR_W       = 8;
    localparam int MAX_LEDS     = 256;
    localparam int LATCH_CYCLES = 10;
    // go-low cycles counted at frame_done: NEXT, the latch gap, and the pulse cycle itself
    localparam int EXP_GAP      = LATCH_CYCLES + 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              loop_en = 1'b0;
    logic [ADDR_W:0]   led_count = '0;
    logic              pix_rd;
    logic [ADDR_W-1:0] pix_addr;
    logic [23:0]       pix_data = '0;
    logic [23:0]       ship_data;
    logic              ship_go;
    logic              ship_done;
    logic              busy;
    logic              frame_done;

    logic              model_done = 1'b0;
    logic              spur_done = 1'b0;
    int                done_lat = 4;

    assign ship_done = model_done | spur_done;

    grb_frame_sequencer #(
        .ADDR_W       (ADDR_W),
        .MAX_LEDS     (MAX_LEDS),
        .LATCH_CYCLES (LATCH_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .loop_en    (loop_en),
        .led_count  (led_count),
        .pix_rd     (pix_rd),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .ship_data  (ship_data),
        .ship_go    (ship_go),
        .ship_done  (ship_done),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic [23:0] mem [256];

    // Pixel RAM: data for a read strobe appears in the following cycle only
    logic rd_pend = 1'b0;
    int   rd_a = 0;
    always @(negedge clk) begin
        pix_data = rd_pend ? mem[rd_a] : 24'hBADBAD;
        rd_pend  = pix_rd;
        rd_a     = int'(pix_addr);
    end

    // Shipper: raises done in the done_lat-th cycle of go
    int go_cnt = 0;
    always @(negedge clk) begin
        if (ship_go) begin
            go_cnt++;
            model_done = (go_cnt == done_lat);
        end else begin
            go_cnt     = 0;
            model_done = 1'b0;
        end
    end

    // Observation log; scenarios read it relative to indices taken beforehand
    int          rd_q[$];
    logic [23:0] word_q[$];
    int          run_q[$];
    int          fd_gap_q[$];
    int          fd_addr_q[$];
    logic        fd_rd_q[$];
    logic        fd_busy_q[$];
    logic        fd_pbusy_q[$];
    int          fd_cnt = 0;
    int          busy_cyc = 0;
    int          stable_err = 0;
    int          fd_long_err = 0;
    int          since_go = 0;
    int          run_len = 0;
    logic [23:0] hold_word = '0;
    logic        go_prev = 1'b0;
    logic        busy_prev = 1'b0;
    logic        fd_prev = 1'b0;

    always @(negedge clk) begin
        if (pix_rd) rd_q.push_back(int'(pix_addr));
        if (busy) busy_cyc++;
        if (ship_go) begin
            if (!go_prev) begin
                word_q.push_back(ship_data);
                hold_word = ship_data;
                run_len   = 1;
            end else begin
                run_len++;
                if (ship_data != hold_word) stable_err++;
            end
            since_go = 0;
        end else begin
            if (go_prev) run_q.push_back(run_len);
            since_go++;
        end
        if (frame_done) begin
            fd_cnt++;
            fd_gap_q.push_back(since_go);
            fd_addr_q.push_back(int'(pix_addr));
            fd_rd_q.push_back(pix_rd);
            fd_busy_q.push_back(busy);
            fd_pbusy_q.push_back(busy_prev);
            if (fd_prev) fd_long_err++;
        end
        go_prev   = ship_go;
        busy_prev = busy;
        fd_prev   = frame_done;
    end

    int compared = 0;
    int mismatched = 0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [ADDR_W:0] cnt, input int dlat);
        done_lat  = dlat;
        led_count = cnt;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitFd(input int target, input int budget);
        int n;
        n = 0;
        while ((fd_cnt < target) && (n < budget)) begin
            tick();
            n++;
        end
        checkOutput("frame_done_wait", (fd_cnt >= target) ? 1 : 0, 1);
    endtask

    typedef struct {
        logic [ADDR_W:0] count;
        int              dlat;
        int              exp_pix;
        int              exp_last;
    } vec_t;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : main
        vec_t vecs[6];
        int   rd0, w0, r0, f0, b0, s0, err, last, n;

        vecs[0] = '{9'd3,   4,  3,   2};
        vecs[1] = '{9'd1,   1,  1,   0};
        vecs[2] = '{9'd300, 2,  256, 255};
        vecs[3] = '{9'd256, 1,  256, 255};
        vecs[4] = '{9'd7,   3,  7,   6};
        vecs[5] = '{9'd2,   50, 2,   1};

        for (int i = 0; i < 256; i++) begin
            mem[i] = {i[7:0], ~i[7:0], i[7:0] ^ 8'hA5};
        end
        mem[0] = 24'h00FF00;
        mem[1] = 24'h123456;
        mem[2] = 24'hABCDEF;

        // Reset state, no clock edge needed for outputs
        #2;
        checkOutput("reset_pix_rd", pix_rd, 0);
        checkOutput("reset_ship_go", ship_go, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_frame_done", frame_done, 0);
        checkOutput("reset_pix_addr", pix_addr, 0);
        checkOutput("reset_ship_data", ship_data, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // First-pixel latency: pix_rd in cycle 1, capture in 2, go in 3
        done_lat  = 1;
        led_count = 9'd1;
        start     = 1'b1;
        f0        = fd_cnt;
        tick();
        start = 1'b0;
        checkOutput("lat_c1_pix_rd", pix_rd, 1);
        checkOutput("lat_c1_addr", pix_addr, 0);
        checkOutput("lat_c1_busy", busy, 1);
        tick();
        checkOutput("lat_c2_pix_rd", pix_rd, 0);
        checkOutput("lat_c2_go", ship_go, 0);
        tick();
        checkOutput("lat_c3_go", ship_go, 1);
        checkOutput("lat_c3_data", ship_data, mem[0]);
        tick();
        checkOutput("lat_c4_go", ship_go, 0);
        waitFd(f0 + 1, 100);
        tick();

        // Table of single-shot frames
        for (int v = 0; v < 6; v++) begin
            rd0 = rd_q.size(); w0 = word_q.size(); r0 = run_q.size();
            f0 = fd_cnt; s0 = stable_err;
            applyStimulus(vecs[v].count, vecs[v].dlat);
            waitFd(f0 + 1, vecs[v].exp_pix * (vecs[v].dlat + 4) + LATCH_CYCLES + 50);
            for (int k = 0; k < 4; k++) tick();
            checkOutput($sformatf("v%0d_pix_count", v), rd_q.size() - rd0, vecs[v].exp_pix);
            err = 0;
            for (int i = 0; i < vecs[v].exp_pix; i++) begin
                if ((rd_q.size() <= rd0 + i) || (rd_q[rd0 + i] != i)) err++;
            end
            checkOutput($sformatf("v%0d_addr_seq_errs", v), err, 0);
            last = (rd_q.size() > rd0) ? rd_q[rd_q.size() - 1] : -1;
            checkOutput($sformatf("v%0d_last_addr", v), last, vecs[v].exp_last);
            checkOutput($sformatf("v%0d_go_runs", v), run_q.size() - r0, vecs[v].exp_pix);
            err = 0;
            for (int i = 0; i < vecs[v].exp_pix; i++) begin
                if ((run_q.size() <= r0 + i) || (run_q[r0 + i] != vecs[v].dlat)) err++;
                if ((word_q.size() <= w0 + i) || (word_q[w0 + i] != mem[i])) err++;
            end
            checkOutput($sformatf("v%0d_word_run_errs", v), err, 0);
            checkOutput($sformatf("v%0d_data_unstable", v), stable_err - s0, 0);
            checkOutput($sformatf("v%0d_frame_dones", v), fd_cnt - f0, 1);
            if (fd_gap_q.size() > f0) begin
                checkOutput($sformatf("v%0d_latch_gap", v), fd_gap_q[f0], EXP_GAP);
                checkOutput($sformatf("v%0d_busy_at_fd", v), fd_busy_q[f0], 0);
                checkOutput($sformatf("v%0d_busy_before_fd", v), fd_pbusy_q[f0], 1);
            end else begin
                checkOutput($sformatf("v%0d_fd_recorded", v), 0, 1);
            end
            checkOutput($sformatf("v%0d_idle_after", v), busy, 0);
        end
        checkOutput("frame_done_width", fd_long_err, 0);

        // led_count of zero: start is ignored
        rd0 = rd_q.size(); f0 = fd_cnt; b0 = busy_cyc;
        led_count = '0;
        start = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        checkOutput("zero_busy_cycles", busy_cyc - b0, 0);
        checkOutput("zero_pix_rd", rd_q.size() - rd0, 0);
        checkOutput("zero_frame_done", fd_cnt - f0, 0);

        // Continuous refresh, then loop_en cleared during the third frame
        rd0 = rd_q.size(); f0 = fd_cnt;
        loop_en = 1'b1;
        applyStimulus(9'd2, 2);
        waitFd(f0 + 2, 200);
        loop_en = 1'b0;
        waitFd(f0 + 3, 100);
        for (int k = 0; k < 8; k++) tick();
        checkOutput("loop_frame_dones", fd_cnt - f0, 3);
        checkOutput("loop_pix_count", rd_q.size() - rd0, 6);
        checkOutput("loop_idle_after", busy, 0);
        if (fd_gap_q.size() >= f0 + 3) begin
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("loop_fd%0d_pix_rd", i), fd_rd_q[f0 + i], 1);
                checkOutput($sformatf("loop_fd%0d_addr", i), fd_addr_q[f0 + i], 0);
                checkOutput($sformatf("loop_fd%0d_busy", i), fd_busy_q[f0 + i], 1);
            end
            err = 0;
            for (int i = 0; i < 3; i++) if (fd_gap_q[f0 + i] != EXP_GAP) err++;
            checkOutput("loop_gap_errs", err, 0);
            checkOutput("loop_last_fd_busy", fd_busy_q[f0 + 2], 0);
        end else begin
            checkOutput("loop_fd_recorded", 0, 1);
        end

        // Spurious ship_done in IDLE and in LATCH
        b0 = busy_cyc;
        spur_done = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        spur_done = 1'b0;
        checkOutput("spur_idle_busy", busy_cyc - b0, 0);
        rd0 = rd_q.size(); f0 = fd_cnt;
        applyStimulus(9'd1, 2);
        n = 0;
        while (!ship_go && n < 20) begin tick(); n++; end
        while (ship_go && n < 40) begin tick(); n++; end
        checkOutput("spur_reached_gap", (n < 40) ? 1 : 0, 1);
        for (int k = 0; k < 3; k++) tick();
        spur_done = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        spur_done = 1'b0;
        waitFd(f0 + 1, 50);
        for (int k = 0; k < 4; k++) tick();
        checkOutput("spur_frame_dones", fd_cnt - f0, 1);
        checkOutput("spur_pix_count", rd_q.size() - rd0, 1);
        if (fd_gap_q.size() > f0) checkOutput("spur_latch_gap", fd_gap_q[f0], EXP_GAP);

        // Re-pulsed start and led_count changes mid-frame are ignored
        rd0 = rd_q.size(); r0 = run_q.size(); f0 = fd_cnt;
        applyStimulus(9'd4, 3);
        for (int k = 0; k < 8; k++) tick();
        led_count = 9'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        led_count = 9'd9;
        waitFd(f0 + 1, 100);
        for (int k = 0; k < 4; k++) tick();
        checkOutput("ignore_pix_count", rd_q.size() - rd0, 4);
        checkOutput("ignore_go_runs", run_q.size() - r0, 4);
        checkOutput("ignore_last_addr", (rd_q.size() > 0) ? rd_q[rd_q.size() - 1] : -1, 3);
        checkOutput("ignore_frame_dones", fd_cnt - f0, 1);

        // Asynchronous reset while shipping the second pixel
        r0 = run_q.size();
        applyStimulus(9'd3, 50);
        n = 0;
        while ((run_q.size() == r0 || !ship_go) && n < 200) begin tick(); n++; end
        checkOutput("rst_reached_ship", ship_go, 1);
        for (int k = 0; k < 5; k++) tick();
        reset = 1'b0;
        #1;
        checkOutput("rst_ship_go", ship_go, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_pix_rd", pix_rd, 0);
        checkOutput("rst_pix_addr", pix_addr, 0);
        checkOutput("rst_ship_data", ship_data, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        rd0 = rd_q.size(); f0 = fd_cnt;
        applyStimulus(9'd2, 2);
        waitFd(f0 + 1, 100);
        tick();
        checkOutput("rst_restart_pix_count", rd_q.size() - rd0, 2);
        checkOutput("rst_restart_first_addr", (rd_q.size() > rd0) ? rd_q[rd0] : -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/grb_frame_sequencer.md
Name: grb_frame_sequencer

Overview:
Frame-level controller for the GRB pixel shipper. On a start request it walks a pixel memory from address 0 to led_count-1 and fetches each 24-bit GRB word. For each word it runs a go/done handshake with the shipper, then holds the line idle for the LED latch gap. It supports single-shot and continuous-refresh modes and sits between the pixel RAM and the shipper's state machine.

Parameters:
ADDR_W, 8, pixel memory address width
MAX_LEDS, 256, maximum LEDs per frame; led_count above this is clamped to it
LATCH_CYCLES, 5000, idle clocks after the last pixel (50 us at 100 MHz); latch counter width clog2(LATCH_CYCLES+1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  frame request; sampled only in IDLE
loop_en  input  1  1 = restart automatically after each latch gap
led_count  input  ADDR_W+1  LEDs in frame; sampled when a frame begins
pix_rd  output  1  pixel memory read strobe, one cycle per pixel
pix_addr  output  ADDR_W  pixel memory address, registered
pix_data  input  24  memory read data, valid the cycle after pix_rd
ship_data  output  24  GRB word to shipper, registered
ship_go  output  1  shipper request
ship_done  input  1  shipper completion pulse
busy  output  1  high in every state except IDLE
frame_done  output  1  one-cycle pulse at end of latch gap

Behaviour:
- Reset (async, reset=0): state IDLE; pix_addr=0, ship_data=0, latch counter=0, frame count=0; pix_rd, ship_go, busy, frame_done all 0 immediately (no clock needed). Reset mid-frame drops ship_go at once. The next frame after release starts at address 0.
- States: IDLE, FETCH, LOAD, SHIP, NEXT, LATCH. pix_rd=1 only in FETCH. ship_go=1 only in SHIP. Both are decoded from the state register, glitch-free.
- IDLE: on start=1, if the clamped led_count is 0, ignore start and stay in IDLE. Otherwise capture the clamped count, set pix_addr=0, go to FETCH.
- FETCH (1 cycle) -> LOAD.
- LOAD (1 cycle): ship_data <= pix_data at the end of the cycle -> SHIP.
- SHIP: ship_go held high and ship_data stable until ship_done=1 is sampled -> NEXT.
- NEXT (1 cycle, ship_go=0): guarantees at least one low cycle of go between pixels.
  - If pix_addr == count-1, clear the latch counter and go to LATCH.
  - Else pix_addr+1, go to FETCH.
- LATCH: all handshake outputs low; count LATCH_CYCLES clocks. On the final count, pulse frame_done for 1 cycle (registered, high in the first cycle after LATCH).
  - If loop_en=1, go to FETCH with pix_addr=0 and led_count re-sampled. If the re-sampled count is 0, go to IDLE instead.
  - Else go to IDLE.
- Timing per pixel: start sampled at edge 0 -> pix_rd cycle 1 -> capture cycle 2 -> ship_go from cycle 3. Per-pixel overhead beyond the shipper's time is 3 cycles (FETCH, LOAD, NEXT).
- ship_done outside SHIP is ignored. start while busy is ignored; no queuing.
- loop_en is sampled only at LATCH exit. Clearing it mid-frame completes the current frame, then IDLE.
- led_count changes mid-frame have no effect. Address arithmetic never wraps because the count is clamped to MAX_LEDS ≤ 2^ADDR_W.

Test Plan:
- LATCH_CYCLES=10, led_count=3, mem={0x00FF00,0x123456,0xABCDEF}, shipper model pulses done 4 cycles after go, start pulse -> pix_rd at addr 0,1,2. ship_data presents the three words in order with ship_go high 4 cycles each and ≥1 low cycle between. After the last done: 10 idle cycles, frame_done one cycle, busy falls in the same cycle frame_done rises.
- led_count=0 with start -> busy stays 0, no pix_rd, no frame_done. led_count=300 (MAX_LEDS=256) -> exactly 256 pixels shipped, last pix_addr=255.
- loop_en=1, led_count=2 -> frames repeat back-to-back, pix_addr returns to 0 right after each frame_done. Clear loop_en mid-frame -> exactly one more frame_done, then IDLE.
- Shipper holds done low for 50 cycles -> ship_go stays high and ship_data unchanged for all 50 cycles. Spurious ship_done in LATCH/IDLE -> no state change.
- reset low asynchronously while in SHIP -> ship_go, busy low before the next clk edge. After release, start -> fetch begins at addr 0.
- start re-pulsed during a frame, led_count changed mid-frame -> no effect; frame ships the originally sampled count.
